add_seq: RTL and testbench

Multi-cycle wide adder sequencer: adds two WIDTH-bit operands by driving one shared 4-bit ripple-carry slice (`rca4`) once per clock, least-significant nibble first. The carry is registered between passes. Operands enter through a valid/ready handshake, and the result leaves through a second valid/ready handshake. The block sits beside the 4-bit adder datapath and sequences it, trading latency for area when wide sums are needed.

---
 rtl/add_seq_pkg.sv | 11 +
 rtl/rca4.sv | 18 +
 rtl/add_seq.sv | 108 ++++++++++
 tb/tb_add_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared constants and state encoding for the add_seq multi-cycle adder.
`timescale 1ns/1ps
package add_seq_pkg;
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/rca4.sv
// 4-bit ripple-carry adder slice, the datapath shared by add_seq.
`timescale 1ns/1ps
module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[4];
endmodule

// File: rtl/add_seq.sv
// Wide adder that reuses one rca4 slice per clock, LS nibble first.
// Optional signed-overflow output enabled by defining ADD_SEQ_OVF_EN.
`timescale 1ns/1ps
module add_seq
  import add_seq_pkg::*;
#(
  parameter  int WIDTH  = 16,
  localparam int NSLICE = WIDTH / SLICE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef ADD_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [3:0]       sl_s;
  logic             sl_co;
  logic             last;
  logic             accept;

  assign last = (cnt == CW'(NSLICE - 1));

  rca4 u_slice (
    .a  (a_sh[SLICE_W-1:0]),
    .b  (b_sh[SLICE_W-1:0]),
    .ci (carry),
    .s  (sl_s),
    .co (sl_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_RUN;
      ST_RUN:  if (last)      state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs come from registered state only; rst just masks in_ready.
  always_comb begin
    in_ready  = (state == ST_IDLE) && !rst;
    out_valid = (state == ST_DONE);
    accept    = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          a_sh  <= a;
          b_sh  <= b;
          carry <= ci;
          cnt   <= '0;
        end
        ST_RUN: begin
          a_sh  <= {{SLICE_W{1'b0}}, a_sh[WIDTH-1:SLICE_W]};
          b_sh  <= {{SLICE_W{1'b0}}, b_sh[WIDTH-1:SLICE_W]};
          s_sh  <= {sl_s, s_sh[WIDTH-1:SLICE_W]};
          carry <= sl_co;
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign s  = s_sh;
  assign co = carry;

`ifdef ADD_SEQ_OVF_EN
  // Signed overflow judged on the top nibble only, during the final pass.
  always_ff @(posedge clk) begin
    if (rst)
      ovf <= 1'b0;
    else if (state == ST_RUN && last)
      ovf <= (a_sh[SLICE_W-1] == b_sh[SLICE_W-1]) && (sl_s[SLICE_W-1] != a_sh[SLICE_W-1]);
  end
`endif
endmodule

// File: tb/tb_add_seq.sv
// Scoreboard bench for add_seq (WIDTH=16): driver queues expectations, monitor checks results.
`timescale 1ns/1ps
module tb_add_seq;
  localparam int WIDTH  = 16;
  localparam int NSLICE = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             ci = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             in_ready, out_valid, co;
  logic [WIDTH-1:0] s;
`ifdef ADD_SEQ_OVF_EN
  logic             ovf;
`endif

  add_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co)
`ifdef ADD_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   stall_mode = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tci,
                      input logic [WIDTH-1:0] es, input logic eco, input logic eovf);
    exp_t e;
    int   k;
    a = ta; b = tb_; ci = tci; in_valid = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 200) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    e.s = es; e.co = eco; e.ovf = eovf; e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); ci = 1'($urandom);
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 1000; k++) begin
      if (sb.size() == 0 && !out_valid) break;
      @(posedge clk);
    end
    if (k == 1000) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // Monitor: result check, hold stability, in_ready blocking, and accept-to-valid latency.
  logic             prev_ov = 1'b0;
  logic             hold = 1'b0;
  logic [WIDTH-1:0] hs;
  logic             hco;
  exp_t             me;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        chk("in_ready_low_in_done", in_ready, 32'd0);
        if (hold) begin
          chk("s_stable", s, hs);
          chk("co_stable", co, hco);
        end
        // Accept on edge T: out_valid appears after edge T+NSLICE, i.e. in cycle T+NSLICE+1.
        if (!prev_ov && sb.size() > 0) chk("latency", cyc - sb[0].acc, NSLICE);
        if (out_ready) begin
          if (sb.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
          else begin
            me = sb.pop_front();
            chk("sum", s, me.s);
            chk("carry_out", co, me.co);
`ifdef ADD_SEQ_OVF_EN
            chk("overflow", ovf, me.ovf);
`endif
          end
          hold = 1'b0;
        end else begin
          hold = 1'b1; hs = s; hco = co;
        end
      end else hold = 1'b0;
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
      hold = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] ra, rb, rs;
    logic             rci, rco, rovf;
    int               k;

    // Reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_s", s, 32'd0);
    chk("rst_co", co, 32'd0);
    chk("rst_in_ready", in_ready, 32'd0);
`ifdef ADD_SEQ_OVF_EN
    chk("rst_ovf", ovf, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 32'd1);
    @(posedge clk); #1;

    // Basic and full-ripple cases
    out_ready = 1'b1;
    send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    wait_drain();
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    wait_drain();

    // Backpressure with a new request pending
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (k == 20) chk("bp_valid_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; ci = 1'b1; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_release", in_ready, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_accept_next", in_ready, 32'd1);
    begin
      exp_t e;
      e.s = 16'h0000; e.co = 1'b1; e.ovf = 1'b0; e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();

    // Reset in the second RUN cycle
    a = 16'h5A5A; b = 16'h1234; ci = 1'b0; in_valid = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mr_in_ready_forced", in_ready, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_out_valid", out_valid, 32'd0);
    chk("mr_s", s, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_idle", in_ready, 32'd1);
    chk("mr_no_result", out_valid, 32'd0);
    @(posedge clk); #1;
    send(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    wait_drain();

    // Signed overflow vectors
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    send(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    wait_drain();

    // Random operands with random result stalls
    stall_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rci = 1'($urandom);
      {rco, rs} = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rci};
      rovf = (ra[WIDTH-1] == rb[WIDTH-1]) && (rs[WIDTH-1] != ra[WIDTH-1]);
      send(ra, rb, rci, rs, rco, rovf);
    end
    stall_mode = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
